mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_2000, 16-byte register window base; compare addr[31:4] only.
REQ-002 Parameter CLKS_PER_BIT, default 868, baud divisor reset value (100 MHz / 115200).
REQ-003 Parameter FIFO_DEPTH, default 4, TX FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  system clock; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mem_en  input  1  bus access enable from the CPU memory stage.
REQ-007 mem_we  input  1  1 = write, 0 = read.
REQ-008 mem_bs  input  2  access size; ignored, any size accepted.
REQ-009 addr  input  32  byte address.
REQ-010 data_in  input  32  write data.
REQ-011 data_out  output  32  registered read data.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 tx_busy  output  1  high while a frame is shifting or the FIFO is non-empty.

Function
REQ-014 hit = mem_en & (addr[31:4] == BASE_ADDR[31:4]); offset = addr[3:2].
REQ-015 Access strobe = hit & ~hit_q, where hit_q is hit registered; one access per enable assertion, however many cycles mem_en is held.
REQ-016 Offset 0 TXDATA: a write pushes data_in[7:0] into the FIFO; a read returns 0.
REQ-017 Offset 1 STATUS (read-only): bit0 shifting, bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[8:4] fifo count; all other bits 0.
REQ-018 Offset 2 BAUDDIV: read/write bits[15:0]; a written value of 0 is stored as 1; upper bits read 0.
REQ-019 Offset 3: reserved; writes ignored, reads return 0.
REQ-020 Read latency: data_out updates on the posedge of the read strobe and holds until the next read strobe.
REQ-021 A STATUS read clears overflow after data_out captures it.
REQ-022 Push while full, with no pop in the same cycle: byte dropped, overflow set. Push and pop in the same cycle while full: push accepted.
REQ-023 FSM states: IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty: pop the byte, latch BAUDDIV into the bit divisor.
- START: drive tx low for div cycles.
- DATA: drive 8 bits, LSB first, div cycles each.
- STOP: drive tx high for div cycles, then -> IDLE.
REQ-024 Frame length is exactly 10*div cycles; a back-to-back frame starts START on the cycle after STOP ends.
REQ-025 A BAUDDIV write during a frame takes effect at the next frame start only.
REQ-026 tx is a registered output; no combinational path from bus inputs to tx.

Reset
REQ-027 On rst: tx=1, tx_busy=0, data_out=0, FIFO empty, overflow=0, BAUDDIV=CLKS_PER_BIT, FSM=IDLE, hit_q=0.
REQ-028 Reset mid-frame aborts the frame immediately; tx returns high asynchronously; queued bytes are discarded.

Structure
REQ-029 Package uart_pkg holds the register offsets, STATUS bit positions, FSM state encoding and default divisor.
REQ-030 Sub-module uart_tx_fifo (synchronous FIFO: push, pop, full, empty, count) is instantiated once; the bus decode and the shifter stay in mmio_uart_tx.

Verification
REQ-031 Directed scenarios the bench must cover:
- BAUDDIV=4, write 0x55 to TXDATA -> tx sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit; tx_busy low 40 cycles after the frame starts.
- mem_en held 2 cycles for one write of 0xA3 -> exactly one frame is sent.
- 6 writes back-to-back with FIFO_DEPTH=4, div=868 -> 5 frames sent (4 queued + 1 popped into the shifter); STATUS.bit3=1; a second STATUS read shows bit3=0.
- BAUDDIV write of 2 during a div=8 frame -> current frame stays 80 cycles; next frame is 20 cycles.
- rst asserted mid-DATA -> tx=1 that cycle; STATUS reads 0x0004 after rst deasserts.
- Write 0 to BAUDDIV, read BAUDDIV -> returns 1; read of offset 3 -> returns 0; access outside the window -> no state change.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS layout, shifter states and default divisor for the MMIO UART
package uart_pkg;
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam int ST_SHIFTING = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_CNT_LSB  = 4;
    localparam int ST_CNT_W    = 5;

    localparam int DEFAULT_DIV = 868;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // A zero divisor would never end a bit; treat it as the fastest legal rate.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the shifter; head byte is visible before it is popped
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_push,
    input  logic [7:0]          i_din,
    input  logic                i_pop,
    output logic [7:0]          o_dout,
    output logic                o_full,
    output logic                o_empty,
    output logic [ST_CNT_W-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]          r_mem [DEPTH];
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       r_rp;
    logic [ST_CNT_W-1:0] r_cnt;
    logic                w_wr;
    logic                w_rd;

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_rd    = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_rd);
    assign o_full  = r_cnt == ST_CNT_W'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];

    // Storage array; contents only matter once written
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wp] <= i_din;

    // Pointers and occupancy; reset discards anything queued
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + ST_CNT_W'(w_wr) - ST_CNT_W'(w_rd);
        end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, status and baud divisor registers
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          CLKS_PER_BIT = DEFAULT_DIV,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_bs,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        tx_busy
);
    logic                w_hit;
    logic                w_stb;
    logic                w_wr;
    logic                w_rd;
    logic                w_push;
    logic                w_load;
    logic                w_full;
    logic                w_empty;
    logic                w_bit_end;
    logic                w_unused;
    logic [1:0]          w_off;
    logic [7:0]          w_head;
    logic [ST_CNT_W-1:0] w_count;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;

    logic                r_hit_q;
    logic                r_ovf;
    logic                r_tx;
    logic [31:0]         r_data_out;
    logic [15:0]         r_baud;
    logic [15:0]         r_div;
    logic [15:0]         r_cnt;
    logic [2:0]          r_bit;
    logic [7:0]          r_sh;
    state_t              r_state;

    // One access per enable assertion: only the rising edge of a hit acts.
    assign w_hit     = mem_en & (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = addr[3:2];
    assign w_stb     = w_hit & ~r_hit_q;
    assign w_wr      = w_stb & mem_we;
    assign w_rd      = w_stb & ~mem_we;
    assign w_push    = w_wr & (w_off == OFF_TXDATA);
    assign w_bit_end = r_cnt == r_div - 16'd1;
    // Loading straight out of STOP keeps back-to-back frames gapless.
    assign w_load    = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
    assign w_unused  = ^{mem_bs, addr[1:0], data_in[31:16]};

    assign tx       = r_tx;
    assign data_out = r_data_out;
    assign tx_busy  = (r_state != S_IDLE) | ~w_empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (data_in[7:0]),
        .i_pop   (w_load),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Read mux: STATUS snapshot, BAUDDIV, zero for TXDATA and the reserved slot
    always_comb begin
        w_status                         = '0;
        w_status[ST_SHIFTING]            = r_state != S_IDLE;
        w_status[ST_FULL]                = w_full;
        w_status[ST_EMPTY]               = w_empty;
        w_status[ST_OVF]                 = r_ovf;
        w_status[ST_CNT_LSB +: ST_CNT_W] = w_count;
        w_rdata = ((w_off == OFF_TXDATA) | (w_off == OFF_RSVD)) ? '0 :
                  (w_off == OFF_STATUS) ? w_status : {16'h0, r_baud};
    end

    // Bus side: edge detect, read capture, divisor register, sticky overflow
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_hit_q    <= 1'b0;
            r_data_out <= '0;
            r_baud     <= 16'(CLKS_PER_BIT);
            r_ovf      <= 1'b0;
        end else begin
            r_hit_q <= w_hit;
            if (w_wr && w_off == OFF_BAUDDIV) r_baud <= clamp_div(data_in[15:0]);
            if (w_rd) r_data_out <= w_rdata;
            if (w_rd && w_off == OFF_STATUS) r_ovf <= 1'b0;
            else if (w_push & w_full & ~w_load) r_ovf <= 1'b1;
        end

    // Shifter FSM: start bit, 8 data bits LSB first, stop bit, each r_div cycles
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_div   <= 16'(CLKS_PER_BIT);
            r_bit   <= '0;
            r_sh    <= '0;
        end else if (w_load) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_div   <= r_baud;
            r_bit   <= '0;
            r_sh    <= w_head;
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_START: begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + 16'd1;
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_sh[0];
                    end
                end
                S_DATA: begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + 16'd1;
                    if (w_bit_end && r_bit == 3'd7) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else if (w_bit_end) begin
                        r_bit <= r_bit + 3'd1;
                        r_sh  <= r_sh >> 1;
                        r_tx  <= r_sh[1];
                    end
                end
                S_STOP: begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + 16'd1;
                    if (w_bit_end) r_state <= S_IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bus stimulus with read and serial-frame scoreboards
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_2000;

    typedef struct {
        logic [7:0] b;
        int         div;
        bit         abort;
        bit         b2b;
    } frm_t;

    typedef struct {
        string       n;
        logic [31:0] v;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_bs = 2'b10;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        tx;
    logic        tx_busy;
    logic        rd_issue = 1'b0;

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_end = -10;
    frm_t  fq[$];
    rexp_t rq[$];

    frm_t       f;
    int         bad;
    bit         ab;
    logic [7:0] rx;
    int         s;
    rexp_t      r;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(868), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_bs   (mem_bs),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] d,
                       input int hold, input logic track);
        @(negedge clk);
        mem_en = 1'b1; mem_we = we; addr = a; data_in = d; rd_issue = track;
        repeat (hold) @(negedge clk);
        mem_en = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(a, 1'b1, d, 1, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string n);
        rq.push_back('{n, exp});
        bus(a, 1'b0, '0, 1, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!tx_busy && fq.size() == 0) break;
        end
        if (i == budget) begin
            n_vec++; n_bad++;
            $display("FAIL %s: still busy=%b with %0d frames pending after %0d cycles, want idle", name, tx_busy, fq.size(), budget);
        end
    endtask

    task automatic wait_start(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) break;
        end
        if (i == budget) begin
            n_vec++; n_bad++;
            $display("FAIL %s: tx=%b after %0d cycles, want start bit 0", name, tx, budget);
        end
    endtask

    // Read scoreboard: data_out is compared just after the capturing edge.
    always @(posedge clk) if (rd_issue) begin
        #1;
        if (rq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL read_scoreboard: got 0x%0h, want no read", data_out);
        end else begin
            r = rq.pop_front();
            chk(r.n, data_out, r.v);
        end
    end

    // Frame scoreboard: every cycle of a frame is checked against the expected bit.
    initial begin : frame_mon
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                if (fq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL frame_scoreboard: got frame start at cycle %0d, want none", cyc);
                    for (int i = 0; i < 20000 && tx_busy && !rst; i++) @(negedge clk);
                end else begin
                    f = fq.pop_front(); bad = 0; ab = 1'b0; rx = '0; s = cyc;
                    if (f.b2b) chk($sformatf("frame_gap_%02h", f.b), s - last_end - 1, 0);
                    for (int k = 0; k < 10 * f.div; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst) begin ab = 1'b1; break; end
                        if (tx !== ((k < f.div) ? 1'b0 : (k >= 9 * f.div) ? 1'b1 : f.b[k / f.div - 1])) bad++;
                        if (k >= f.div && k < 9 * f.div && k % f.div == f.div / 2) rx[k / f.div - 1] = tx;
                    end
                    last_end = cyc;
                    chk($sformatf("frame_abort_%02h", f.b), {31'b0, ab}, {31'b0, f.abort});
                    if (!ab) begin
                        chk($sformatf("frame_byte_%02h", f.b), {24'b0, rx}, {24'b0, f.b});
                        chk($sformatf("frame_timing_%02h", f.b), bad, 0);
                    end else begin
                        for (int i = 0; i < 100 && rst; i++) @(negedge clk);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, tx_busy}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        rst = 1'b0;
        rd(BASE + 4, 32'h0000_0004, "status_reset");
        rd(BASE + 8, 32'd868, "baud_reset");

        // Six writes into a 4-deep FIFO: first byte goes to the shifter, sixth is dropped
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) fq.push_back('{8'(i), 868, 1'b0, bit'(i > 1)});
            wr(BASE, 32'(i));
        end
        rd(BASE + 4, 32'h0000_004B, "status_overflow");
        rd(BASE + 4, 32'h0000_0043, "status_overflow_cleared");
        wait_idle(50000, "overflow_drain");

        // 0x55 at div 4, with busy dropping exactly 40 cycles after the start bit
        wr(BASE + 8, 32'd4);
        rd(BASE, 32'd0, "txdata_read");
        fq.push_back('{8'h55, 4, 1'b0, 1'b0});
        wr(BASE, 32'h55);
        wait_start(50, "t55_start");
        repeat (39) @(negedge clk);
        chk("busy_at_39", {31'b0, tx_busy}, 32'd1);
        @(negedge clk);
        chk("busy_at_40", {31'b0, tx_busy}, 32'd0);
        wait_idle(200, "t55_idle");

        // mem_en held two cycles produces a single frame
        fq.push_back('{8'hA3, 4, 1'b0, 1'b0});
        bus(BASE, 1'b1, 32'hA3, 2, 1'b0);
        wait_idle(200, "ta3_idle");
        repeat (60) @(negedge clk);
        rd(BASE + 4, 32'h0000_0004, "status_after_hold");

        // Divisor change mid-frame applies only to the following frame
        wr(BASE + 8, 32'd8);
        fq.push_back('{8'h0F, 8, 1'b0, 1'b0});
        wr(BASE, 32'h0F);
        wait_start(50, "t0f_start");
        repeat (10) @(negedge clk);
        wr(BASE + 8, 32'd2);
        fq.push_back('{8'hF0, 2, 1'b0, 1'b1});
        wr(BASE, 32'hF0);
        wait_idle(200, "tf0_idle");
        rd(BASE + 8, 32'd2, "baud_two");

        // Zero divisor, reserved slot and out-of-window accesses
        wr(BASE + 8, 32'd0);
        rd(BASE + 8, 32'd1, "baud_zero_clamped");
        rd(BASE + 12, 32'd0, "rsvd_read");
        wr(BASE + 12, 32'h0000_FFFF);
        rd(BASE + 8, 32'd1, "baud_after_rsvd_write");
        wr(BASE + 16, 32'h99);
        wr(32'h0000_1008, 32'd5);
        bus(32'h0000_3004, 1'b0, '0, 1, 1'b0);
        chk("outside_read_dout", data_out, 32'd1);
        repeat (30) @(negedge clk);
        chk("outside_busy", {31'b0, tx_busy}, 32'd0);
        rd(BASE + 8, 32'd1, "baud_after_outside");
        rd(BASE + 4, 32'h0000_0004, "status_after_outside");

        // Reset during the first data bit aborts the frame and flushes the queue
        wr(BASE + 8, 32'd8);
        fq.push_back('{8'h3C, 8, 1'b1, 1'b0});
        wr(BASE, 32'h3C);
        wr(BASE, 32'h81);
        wait_start(50, "t3c_start");
        repeat (10) @(negedge clk);
        chk("pre_rst_tx", {31'b0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'b0, tx}, 32'd1);
        chk("rst_async_busy", {31'b0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("post_rst_busy", {31'b0, tx_busy}, 32'd0);
        rd(BASE + 4, 32'h0000_0004, "status_after_rst");
        rd(BASE + 8, 32'd868, "baud_after_rst");

        repeat (5) @(negedge clk);
        chk("frames_left", fq.size(), 32'd0);
        chk("reads_left", rq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
